// File: rtl/multi_channel_counter_if.sv
`default_nettype none
// ============================================================================
// Module   : multi_channel_counter_if
// Purpose  : Load handshake and snapshot bundle for multi_channel_counter.
// Revision : 1.0 - initial release
// ============================================================================
interface multi_channel_counter_if #(
  parameter int NUM_CH = 2,
  parameter int WIDTH  = 4
);
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic                    load_valid;
  logic [CH_W-1:0]         load_ch;
  logic [WIDTH-1:0]        load_value;
  logic                    load_ready;
  logic                    snap_req;
  logic [NUM_CH*WIDTH-1:0] snap_count;
  logic                    snap_valid;

  modport master (
    output load_valid, load_ch, load_value, snap_req,
    input  load_ready, snap_count, snap_valid
  );

  modport slave (
    input  load_valid, load_ch, load_value, snap_req,
    output load_ready, snap_count, snap_valid
  );
endinterface
`default_nettype wire

// File: rtl/multi_channel_counter.sv
`default_nettype none
// ============================================================================
// Module   : multi_channel_counter
// Purpose  : N-channel 0..LIMIT modulo counter bank with load, clear, wrap
//            pulses and atomic snapshot. MULTI_CHANNEL_COUNTER_CASCADE_EN
//            chains channels into a multi-digit counter.
// Revision : 1.0 - initial release
// ============================================================================
module multi_channel_counter #(
  parameter int NUM_CH = 2,
  parameter int WIDTH  = 4,
  parameter int LIMIT  = 10
) (
  input  wire logic                    clk,
  input  wire logic                    rst,
  input  wire logic [NUM_CH-1:0]       en,
  input  wire logic [NUM_CH-1:0]       dir,
  input  wire logic [NUM_CH-1:0]       clr,
  output logic      [NUM_CH*WIDTH-1:0] count,
  output logic      [NUM_CH-1:0]       wrap,
  multi_channel_counter_if.slave       bus
);
  localparam int               CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [WIDTH-1:0] LIM  = WIDTH'(LIMIT);

  generate
    if (NUM_CH < 1 || LIMIT < 1 || 64'(LIMIT) > ((64'd1 << WIDTH) - 64'd1)) begin : g_bad_params
      $error("multi_channel_counter: LIMIT must be in 1..2^WIDTH-1 and NUM_CH >= 1");
    end
  endgenerate

  logic [NUM_CH-1:0][WIDTH-1:0] count_q, count_d;
  logic [NUM_CH-1:0][WIDTH-1:0] snap_count_q, snap_count_d;
  logic [NUM_CH-1:0]            wrap_q, wrap_d;
  logic                         snap_valid_q, snap_valid_d;
  logic                         load_ready_q, load_ready_d;

  logic                         load_acc;
  logic                         cnt_req;
  logic                         ld_hit;
  logic                         term;
  logic                         counting;
  logic [WIDTH-1:0]             cur;
`ifdef MULTI_CHANNEL_COUNTER_CASCADE_EN
  logic                         carry;
`endif

  assign load_acc = bus.load_valid && load_ready_q;

  always_comb begin
    count_d  = count_q;
    wrap_d   = '0;
    cnt_req  = 1'b0;
    ld_hit   = 1'b0;
    term     = 1'b0;
    counting = 1'b0;
    cur      = '0;
`ifdef MULTI_CHANNEL_COUNTER_CASCADE_EN
    carry    = 1'b0;
`endif
    for (int i = 0; i < NUM_CH; i++) begin
`ifdef MULTI_CHANNEL_COUNTER_CASCADE_EN
      cnt_req = (i == 0) ? en[i] : carry;
`else
      cnt_req = en[i];
`endif
      ld_hit   = load_acc && (bus.load_ch == CH_W'(i));
      cur      = count_q[i];
      // Values above LIMIT are fault states; treat them as terminal either way.
      term     = dir[i] ? (cur >= LIM) : ((cur == '0) || (cur > LIM));
      counting = cnt_req && !clr[i] && !ld_hit;
      if (clr[i]) begin
        count_d[i] = '0;
      end else if (ld_hit) begin
        count_d[i] = (bus.load_value > LIM) ? LIM : bus.load_value;
      end else if (counting) begin
        if (term) begin
          count_d[i] = dir[i] ? '0 : LIM;
          wrap_d[i]  = 1'b1;
        end else begin
          count_d[i] = dir[i] ? (cur + 1'b1) : (cur - 1'b1);
        end
      end
`ifdef MULTI_CHANNEL_COUNTER_CASCADE_EN
      carry = counting && term;
`endif
    end
  end

  always_comb begin
    snap_count_d = bus.snap_req ? count_q : snap_count_q;
    snap_valid_d = bus.snap_req;
    load_ready_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q      <= '0;
      wrap_q       <= '0;
      snap_count_q <= '0;
      snap_valid_q <= 1'b0;
      load_ready_q <= 1'b0;
    end else begin
      count_q      <= count_d;
      wrap_q       <= wrap_d;
      snap_count_q <= snap_count_d;
      snap_valid_q <= snap_valid_d;
      load_ready_q <= load_ready_d;
    end
  end

  assign count          = count_q;
  assign wrap           = wrap_q;
  assign bus.snap_count = snap_count_q;
  assign bus.snap_valid = snap_valid_q;
  assign bus.load_ready = load_ready_q;
endmodule
`default_nettype wire

// File: tb/tb_multi_channel_counter.sv
`default_nettype none
// ============================================================================
// Module   : tb_multi_channel_counter
// Purpose  : Directed self-checking bench for multi_channel_counter (2x4b, LIMIT 10).
// Revision : 1.0 - initial release
// ============================================================================
module tb_multi_channel_counter;
  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] en, dir, clr;
  logic [7:0] count;
  logic [1:0] wrap;
  int         n_vec = 0;
  int         n_err = 0;

  multi_channel_counter_if #(.NUM_CH(2), .WIDTH(4)) bus ();

  multi_channel_counter #(.NUM_CH(2), .WIDTH(4), .LIMIT(10)) dut (
    .clk   (clk),
    .rst   (rst),
    .en    (en),
    .dir   (dir),
    .clr   (clr),
    .count (count),
    .wrap  (wrap),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    en = 2'b00; dir = 2'b11; clr = 2'b00;
    bus.load_valid = 1'b0; bus.load_ch = 1'b0; bus.load_value = 4'd0;
    bus.snap_req = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    step(); step();
    rst = 1'b0;
    step();
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    bus.snap_req = 1'b1;
    step(); step();
    n_vec++; if (count !== 8'h00) begin n_err++; $display("FAIL reset_count got %h exp 00", count); end
    n_vec++; if (wrap !== 2'b00) begin n_err++; $display("FAIL reset_wrap got %b exp 00", wrap); end
    n_vec++; if (bus.load_ready !== 1'b0) begin n_err++; $display("FAIL reset_ready got %b exp 0", bus.load_ready); end
    n_vec++; if (bus.snap_valid !== 1'b0 || bus.snap_count !== 8'h00)
      begin n_err++; $display("FAIL reset_snap got v=%b c=%h exp v=0 c=00", bus.snap_valid, bus.snap_count); end
    rst = 1'b0;
    bus.snap_req = 1'b0;
    step();
    n_vec++; if (bus.load_ready !== 1'b1) begin n_err++; $display("FAIL ready_after_reset got %b exp 1", bus.load_ready); end
  endtask

  task automatic test_up_count();
    logic [3:0] e;
    do_reset();
    en = 2'b11; dir = 2'b11;
    for (int k = 1; k <= 12; k++) begin
      step();
      e = 4'(k % 11);
      n_vec++; if (count !== {e, e}) begin n_err++; $display("FAIL up_count k=%0d got %h exp %h", k, count, {e, e}); end
      n_vec++; if (wrap !== ((k == 11) ? 2'b11 : 2'b00))
        begin n_err++; $display("FAIL up_wrap k=%0d got %b exp %b", k, wrap, (k == 11) ? 2'b11 : 2'b00); end
    end
  endtask

  task automatic test_down_count();
    logic [3:0] e;
    do_reset();
    en = 2'b01; dir = 2'b00;
    for (int k = 1; k <= 12; k++) begin
      step();
      e = 4'((11 - (k % 11)) % 11);
      n_vec++; if (count !== {4'd0, e}) begin n_err++; $display("FAIL down_count k=%0d got %h exp %h", k, count, {4'd0, e}); end
      n_vec++; if (wrap !== ((k % 11 == 1) ? 2'b01 : 2'b00))
        begin n_err++; $display("FAIL down_wrap k=%0d got %b exp %b", k, wrap, (k % 11 == 1) ? 2'b01 : 2'b00); end
    end
  endtask

  task automatic test_load_clamp();
    do_reset();
    en = 2'b10; dir = 2'b11;
    bus.load_valid = 1'b1; bus.load_ch = 1'b1; bus.load_value = 4'd15;
    step();
    n_vec++; if (count !== 8'hA0 || wrap !== 2'b00)
      begin n_err++; $display("FAIL load_clamp got c=%h w=%b exp c=a0 w=00", count, wrap); end
    bus.load_valid = 1'b0;
    step();
    n_vec++; if (count !== 8'h00 || wrap !== 2'b10)
      begin n_err++; $display("FAIL load_then_wrap got c=%h w=%b exp c=00 w=10", count, wrap); end
  endtask

  task automatic test_clr_priority();
    do_reset();
    en = 2'b01; dir = 2'b11; clr = 2'b01;
    bus.load_valid = 1'b1; bus.load_ch = 1'b0; bus.load_value = 4'd5;
    step();
    n_vec++; if (count !== 8'h00) begin n_err++; $display("FAIL clr_over_load got %h exp 00", count); end
    clr = 2'b00;
    step();
    n_vec++; if (count !== 8'h05 || wrap !== 2'b00)
      begin n_err++; $display("FAIL load_over_en got c=%h w=%b exp c=05 w=00", count, wrap); end
    bus.load_valid = 1'b0;
    step();
    n_vec++; if (count !== 8'h06) begin n_err++; $display("FAIL count_after_load got %h exp 06", count); end
  endtask

  task automatic test_snapshot();
    do_reset();
    bus.load_valid = 1'b1; bus.load_ch = 1'b0; bus.load_value = 4'd7;
    step();
    bus.load_ch = 1'b1; bus.load_value = 4'd3;
    step();
    bus.load_valid = 1'b0;
    n_vec++; if (count !== 8'h37) begin n_err++; $display("FAIL snap_setup got %h exp 37", count); end
    en = 2'b11; dir = 2'b11; bus.snap_req = 1'b1;
    step();
    n_vec++; if (bus.snap_count !== 8'h37 || bus.snap_valid !== 1'b1 || count !== 8'h48)
      begin n_err++; $display("FAIL snapshot got s=%h v=%b c=%h exp s=37 v=1 c=48", bus.snap_count, bus.snap_valid, count); end
    bus.snap_req = 1'b0;
    step();
    n_vec++; if (bus.snap_count !== 8'h37 || bus.snap_valid !== 1'b0 || count !== 8'h59)
      begin n_err++; $display("FAIL snap_hold got s=%h v=%b c=%h exp s=37 v=0 c=59", bus.snap_count, bus.snap_valid, count); end
  endtask

  task automatic test_back_to_back();
    bus.snap_req = 1'b1;
    step();
    n_vec++; if (bus.snap_count !== 8'h59 || bus.snap_valid !== 1'b1 || count !== 8'h6A)
      begin n_err++; $display("FAIL b2b_snap1 got s=%h v=%b c=%h exp s=59 v=1 c=6a", bus.snap_count, bus.snap_valid, count); end
    step();
    n_vec++; if (bus.snap_count !== 8'h6A || bus.snap_valid !== 1'b1 || count !== 8'h70 || wrap !== 2'b01)
      begin n_err++; $display("FAIL b2b_snap2 got s=%h v=%b c=%h w=%b exp s=6a v=1 c=70 w=01", bus.snap_count, bus.snap_valid, count, wrap); end
    bus.snap_req = 1'b0;
  endtask

  task automatic test_reset_midop();
    en = 2'b11; dir = 2'b11;
    bus.load_valid = 1'b1; bus.load_ch = 1'b1; bus.load_value = 4'd9;
    bus.snap_req = 1'b1;
    rst = 1'b1;
    step();
    n_vec++; if (count !== 8'h00 || bus.snap_valid !== 1'b0 || bus.load_ready !== 1'b0)
      begin n_err++; $display("FAIL midop_reset got c=%h v=%b r=%b exp c=00 v=0 r=0", count, bus.snap_valid, bus.load_ready); end
    rst = 1'b0;
    idle_inputs();
    step();
    n_vec++; if (count !== 8'h00 || wrap !== 2'b00 || bus.snap_valid !== 1'b0 || bus.snap_count !== 8'h00)
      begin n_err++; $display("FAIL after_midop got c=%h w=%b v=%b s=%h exp c=00 w=00 v=0 s=00", count, wrap, bus.snap_valid, bus.snap_count); end
  endtask

  task automatic test_cascade();
    int pulses;
    pulses = 0;
    do_reset();
    en = 2'b01; dir = 2'b11;
    for (int k = 1; k <= 121; k++) begin
      step();
      if (wrap[1]) pulses++;
      if (k == 11) begin
        n_vec++; if (count !== 8'h10) begin n_err++; $display("FAIL cascade_carry got %h exp 10", count); end
      end
    end
    n_vec++; if (count !== 8'h00) begin n_err++; $display("FAIL cascade_end got %h exp 00", count); end
    n_vec++; if (pulses !== 1) begin n_err++; $display("FAIL cascade_wrap1 got %0d exp 1", pulses); end
  endtask

  initial begin
    test_reset();
`ifdef MULTI_CHANNEL_COUNTER_CASCADE_EN
    test_cascade();
`else
    test_up_count();
    test_down_count();
    test_load_clamp();
    test_clr_priority();
    test_snapshot();
    test_back_to_back();
    test_reset_midop();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
`default_nettype wire
